// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle line-count position decoder.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [7:0] PAD_CENTRE = 8'd114;
  localparam int         FILT_DEPTH = 4;

endpackage

// File: rtl/paddle_pos_decoder_if.sv
// Paddle timing bus: source drives hsync/window/timing level, decoder returns position.
interface paddle_pos_decoder_if #(
  parameter int CNT_W = 8
);
  logic             hsync;
  logic             pad_en_n;
  logic             pad_out;
  logic [CNT_W-1:0] pos;
  logic             pos_valid;
  logic             overrange;
  logic             busy;

  modport master (
    output hsync, pad_en_n, pad_out,
    input  pos, pos_valid, overrange, busy
  );

  modport slave (
    input  hsync, pad_en_n, pad_out,
    output pos, pos_valid, overrange, busy
  );
endinterface

// File: rtl/paddle_edge_det.sv
// Registered rising-edge detector; RST_VAL sets the history value seen after reset.
module paddle_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (!rst_n) r_d <= RST_VAL;
    else        r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/paddle_pos_decoder.sv
// Converts paddle pad_out high time (in hsync lines) back into a position.
// Optional 4-sample rounded-mean filter on pos: define PADDLE_POS_FILTER_EN.
module paddle_pos_decoder
  import paddle_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_LINES = 255
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  paddle_pos_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAXV   = CNT_W'(MAX_LINES);
  localparam logic [CNT_W-1:0] CENTRE = CNT_W'(PAD_CENTRE);

  logic             w_hs_rise;
  logic             w_en_rise;
  logic             w_cap_en;
  logic [CNT_W-1:0] w_cap;
  logic [CNT_W-1:0] w_pos_next;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pos;
  logic             r_pos_valid;
  logic             r_ovr;
  logic             r_busy;

  paddle_edge_det #(.RST_VAL(1'b0)) u_hs_det (
    .clk(clk_sys), .rst_n(reset_n), .i_d(bus.hsync), .o_rise(w_hs_rise)
  );

  // History resets high so a window already open at reset release is skipped.
  paddle_edge_det #(.RST_VAL(1'b1)) u_en_det (
    .clk(clk_sys), .rst_n(reset_n), .i_d(bus.pad_en_n), .o_rise(w_en_rise)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n)                      r_cnt <= '0;
    else if (!bus.pad_en_n)            r_cnt <= '0;
    else if (w_hs_rise && r_cnt < MAXV) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Capture uses the registered count, i.e. the driver's count at its compare point.
  assign w_cap_en = (r_state == MEASURE) && bus.pad_en_n && (!bus.pad_out || r_cnt == MAXV);
  assign w_cap    = bus.pad_out ? MAXV : r_cnt;

`ifdef PADDLE_POS_FILTER_EN
  logic [CNT_W-1:0] r_hist [FILT_DEPTH-1];
  logic [CNT_W+1:0] w_sum;

  always_comb begin
    w_sum = {2'b00, w_cap} + (CNT_W+2)'(2);
    for (int i = 0; i < FILT_DEPTH-1; i++) w_sum = w_sum + {2'b00, r_hist[i]};
  end

  assign w_pos_next = w_sum[CNT_W+1:2];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < FILT_DEPTH-1; i++) r_hist[i] <= CENTRE;
    end else if (w_cap_en) begin
      r_hist[0] <= w_cap;
      for (int i = 1; i < FILT_DEPTH-1; i++) r_hist[i] <= r_hist[i-1];
    end
  end
`else
  assign w_pos_next = w_cap;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pos       <= CENTRE;
      r_pos_valid <= 1'b0;
      r_ovr       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_pos_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_en_rise) begin
            r_state <= MEASURE;
            r_busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (!bus.pad_en_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_cap_en) begin
            r_pos       <= w_pos_next;
            r_ovr       <= bus.pad_out;
            r_pos_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pos       = r_pos;
  assign bus.pos_valid = r_pos_valid;
  assign bus.overrange = r_ovr;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_paddle_pos_decoder.sv
// Randomized scoreboard bench for paddle_pos_decoder (default build, no filter).
module tb_paddle_pos_decoder;

  localparam int CNT_W = 8;
  localparam int MAXL  = 255;

  typedef struct {
    int pos;
    int ovr;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_pos = 114;
  int   last_ovr = 0;
  exp_t q[$];

  always #5 clk_sys = ~clk_sys;

  paddle_pos_decoder_if #(.CNT_W(CNT_W)) bus ();

  paddle_pos_decoder #(.CNT_W(CNT_W), .MAX_LINES(MAXL)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid must match the oldest outstanding expected capture.
  always @(negedge clk_sys) begin
    if (reset_n && bus.pos_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_pos_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pos", int'(bus.pos), e.pos);
        chk("overrange", int'(bus.overrange), e.ovr);
        chk("busy_at_valid", int'(bus.busy), 0);
      end
    end
  end

  // mode 0: complete window; 1: drop pad_en_n after `at` lines; 2: reset after `at` lines
  task automatic run_window(input int p, input int per, input int mode, input int at);
    int dcnt = 0;
    int left = 0;
    int ph   = 0;
    bit h = 1'b0, hprev = 1'b0, ended = 1'b0;
    @(negedge clk_sys);
    bus.pad_en_n = 1'b0;
    bus.hsync    = 1'b0;
    bus.pad_out  = 1'b1;
    repeat (10) @(negedge clk_sys);
    if (mode == 0) begin
      exp_t e;
      e.pos = (p > MAXL) ? MAXL : p;
      e.ovr = (p > MAXL) ? 1 : 0;
      q.push_back(e);
      last_pos = e.pos;
      last_ovr = e.ovr;
    end
    bus.pad_en_n = 1'b1;
    bus.pad_out  = (p > 0);
    for (int c = 0; c < 3000 && !ended; c++) begin
      @(posedge clk_sys);
      if (h && !hprev) dcnt++;
      hprev = h;
      @(negedge clk_sys);
      if (c == 0) chk("busy_in_window", int'(bus.busy), 1);
      ph++;
      h = ((ph % per) == 0) && (dcnt < MAXL);
      bus.hsync = h;
      if (left > 0) begin
        left--;
        bus.pad_out = 1'($urandom_range(0, 1));
        if (left == 0) ended = 1'b1;
      end else if (mode != 0 && dcnt >= at) begin
        if (mode == 1) begin
          bus.pad_en_n = 1'b0;
        end else begin
          reset_n = 1'b0;
          @(negedge clk_sys);
          chk("reset_pos", int'(bus.pos), 114);
          chk("reset_busy", int'(bus.busy), 0);
          chk("reset_overrange", int'(bus.overrange), 0);
          chk("reset_valid", int'(bus.pos_valid), 0);
          reset_n  = 1'b1;
          last_pos = 114;
          last_ovr = 0;
        end
        ended = 1'b1;
      end else begin
        bus.pad_out = (dcnt < p);
        if (dcnt >= p || dcnt >= MAXL) left = 4;
      end
    end
    if (!ended) chk("window_timeout", 1, 0);
    bus.pad_en_n = 1'b0;
    bus.hsync    = 1'b0;
    repeat (3) @(negedge clk_sys);
    if (mode != 0) begin
      chk("pos_after_cancel", int'(bus.pos), last_pos);
      chk("ovr_after_cancel", int'(bus.overrange), last_ovr);
      chk("busy_after_cancel", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.hsync    = 1'b0;
    bus.pad_en_n = 1'b1;
    bus.pad_out  = 1'b1;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("init_pos", int'(bus.pos), 114);
    chk("init_valid", int'(bus.pos_valid), 0);
    chk("init_overrange", int'(bus.overrange), 0);
    chk("init_busy", int'(bus.busy), 0);

    // Window already open at reset release must not be measured.
    for (int i = 0; i < 20; i++) begin
      bus.hsync   = (i % 3 == 0);
      bus.pad_out = 1'b0;
      @(negedge clk_sys);
    end
    chk("no_window_busy", int'(bus.busy), 0);
    chk("no_window_pos", int'(bus.pos), 114);

    run_window(114, 8, 0, 0);
    run_window(0,   8, 0, 0);
    run_window(255, 4, 0, 0);
    run_window(300, 8, 0, 0);
    run_window(300, 8, 1, 40);
    run_window(60,  8, 0, 0);
    run_window(300, 5, 2, 20);
    run_window(100, 3, 0, 0);
    for (int i = 0; i < 8; i++)
      run_window(int'($urandom_range(0, 265)), int'($urandom_range(2, 5)), 0, 0);
    run_window(300, 2, 1, int'($urandom_range(1, 200)));
    run_window(int'($urandom_range(1, 254)), 2, 0, 0);

    repeat (10) @(negedge clk_sys);
    chk("missing_valids", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
